imem_loader: RTL and testbench

- Writer side of the instruction memory interface; the fetch stage is the reader.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words into instruction memory at consecutive word addresses.
- Holds the pipeline in reset via `cpu_hold` until a complete, checksum-verified program has been loaded.

---
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory interface.
//
// Receives a framed byte stream over a valid/ready handshake:
//   length high byte, length low byte, 4*N payload bytes, then 1 checksum byte.
// Payload words are big-endian (MSB first). The checksum byte is the XOR of
// every payload byte.
//
// Each assembled word is written to consecutive word addresses starting at
// BASE_ADDR. The CPU pipeline is held in reset (cpu_hold) until a complete
// program with a good checksum has been loaded.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data      in   [7:0] stream byte
//   in_valid     in   stream byte valid
//   in_ready     out  loader accepts a byte this cycle
//   im_we        out  instruction memory write strobe (one cycle per word)
//   im_addr      out  [31:0] byte address of the write (word-aligned)
//   im_wdata     out  [31:0] instruction word being written
//   cpu_hold     out  holds the pipeline (PC register) in reset
//   done         out  load completed with a good checksum (sticky)
//   error        out  load failed (sticky)
//   words_loaded out  [15:0] words written in the current or last load
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] LP_MAX_WORDS = 16'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_len;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic [31:0] r_word;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_words_loaded;

  logic        w_xfer;
  logic        w_ready;
  logic [15:0] w_len_full;
  logic [15:0] w_words_done;
  logic        w_last_word;
  logic [31:0] w_word_next;

  assign w_xfer      = in_valid && w_ready;
  assign w_len_full  = {r_len[15:8], in_data};
  assign w_word_next = {r_word[23:0], in_data};

  // words_loaded lags the strobe by one cycle, so a strobe still in flight
  // counts as a completed word when deciding whether this is the last one.
  assign w_words_done = r_words_loaded + {15'd0, r_we};
  assign w_last_word  = (w_words_done + 16'd1) == r_len;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_state_next = S_LEN_HI;
      S_LEN_HI:              if (w_xfer) w_state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_full > LP_MAX_WORDS)  w_state_next = S_ERR;
          else if (w_len_full == 16'd0)   w_state_next = S_CHK;
          else                            w_state_next = S_DATA;
        end
      end
      // Leave on the final byte of the last word; its strobe then lands in
      // the first CHK cycle.
      S_DATA: if (w_xfer && r_byte_idx == 2'd3 && w_last_word) w_state_next = S_CHK;
      S_CHK: begin
        if (w_xfer) w_state_next = (in_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready  = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: w_ready = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign in_ready     = w_ready;
  assign im_we        = r_we;
  assign im_addr      = r_addr;
  assign im_wdata     = r_wdata;
  assign words_loaded = r_words_loaded;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len          <= 16'd0;
      r_byte_idx     <= 2'd0;
      r_csum         <= 8'd0;
      r_word         <= 32'd0;
      r_we           <= 1'b0;
      r_addr         <= BASE_ADDR;
      r_wdata        <= 32'd0;
      r_words_loaded <= 16'd0;
    end else begin
      r_we <= 1'b0;

      // Address and count advance on the edge that ends the strobe cycle.
      if (r_we) begin
        r_addr         <= r_addr + 32'd4;
        r_words_loaded <= r_words_loaded + 16'd1;
      end

      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_len          <= 16'd0;
            r_byte_idx     <= 2'd0;
            r_csum         <= 8'd0;
            r_addr         <= BASE_ADDR;
            r_words_loaded <= 16'd0;
          end
        end
        S_LEN_HI: if (w_xfer) r_len[15:8] <= in_data;
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= in_data;
            r_byte_idx <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // The shift register keeps accepting bytes during the strobe cycle;
            // the word being written is held separately in r_wdata.
            r_word     <= w_word_next;
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= w_word_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge; writes are logged by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int compared   = 0;
  int mismatched = 0;

  // Write log filled by the monitor.
  int          wr_n = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];

  // Frame buffer used by send_frame.
  logic [7:0] frame [16];
  int         frame_len;

  imem_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = im_addr;
        wr_data[wr_n] = im_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte; hold it until in_ready is seen, bounded.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 50) begin
      $display("FAIL send_byte timeout: in_ready=%b required=1", in_ready);
      mismatched++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_len; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      send_byte(frame[i]);
    end
  endtask

  // Wait (bounded) for done or error to rise, then settle one extra cycle.
  task automatic wait_end(input string name);
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 40) begin
      $display("FAIL %s end timeout: done=%b error=%b required one high", name, done, error);
      mismatched++;
    end
    @(negedge clk);
  endtask

  task automatic load_two_word(input logic [7:0] chk);
    frame[0] = 8'h00; frame[1] = 8'h02;
    frame[2] = 8'h8C; frame[3] = 8'h01; frame[4] = 8'h00; frame[5] = 8'h04;
    frame[6] = 8'h00; frame[7] = 8'h22; frame[8] = 8'h18; frame[9] = 8'h20;
    frame[10] = chk;
    frame_len = 11;
  endtask

  task automatic check_two_writes(input string name);
    compared++;
    if (wr_n !== 2) begin
      $display("FAIL %s write count: got %0d required 2", name, wr_n); mismatched++;
    end
    compared++;
    if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h8C010004) begin
      $display("FAIL %s write0: got addr=%h data=%h required addr=00000000 data=8c010004",
               name, wr_addr[0], wr_data[0]); mismatched++;
    end
    compared++;
    if (wr_addr[1] !== 32'd4 || wr_data[1] !== 32'h00221820) begin
      $display("FAIL %s write1: got addr=%h data=%h required addr=00000004 data=00221820",
               name, wr_addr[1], wr_data[1]); mismatched++;
    end
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err,
                              input logic e_hold, input logic [15:0] e_words);
    compared++;
    if (done !== e_done || error !== e_err || cpu_hold !== e_hold) begin
      $display("FAIL %s status: got done=%b error=%b hold=%b required done=%b error=%b hold=%b",
               name, done, error, cpu_hold, e_done, e_err, e_hold); mismatched++;
    end
    compared++;
    if (words_loaded !== e_words) begin
      $display("FAIL %s words_loaded: got %0d required %0d", name, words_loaded, e_words);
      mismatched++;
    end
    compared++;
    if (in_ready !== 1'b0) begin
      $display("FAIL %s in_ready: got %b required 0", name, in_ready); mismatched++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== 32'd0 || im_wdata !== 32'd0) begin
      $display("FAIL reset datapath: got rdy=%b we=%b addr=%h wdata=%h required 0 0 0 0",
               in_ready, im_we, im_addr, im_wdata); mismatched++;
    end
    compared++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
      $display("FAIL reset status: got hold=%b done=%b err=%b words=%0d required 1 0 0 0",
               cpu_hold, done, error, words_loaded); mismatched++;
    end
  endtask

  task automatic test_two_word();
    wr_n = 0;
    load_two_word(8'h93);
    pulse_start();
    compared++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      $display("FAIL two_word after start: got rdy=%b hold=%b required 1 1", in_ready, cpu_hold);
      mismatched++;
    end
    send_frame(0);
    wait_end("two_word");
    check_two_writes("two_word");
    check_status("two_word", 1'b1, 1'b0, 1'b0, 16'd2);
  endtask

  // start from DONE: cpu_hold rises as soon as the state leaves DONE.
  task automatic test_back_to_back();
    wr_n = 0;
    load_two_word(8'h00);
    pulse_start();
    compared++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0 || im_addr !== 32'd0) begin
      $display("FAIL restart: got hold=%b done=%b words=%0d addr=%h required 1 0 0 00000000",
               cpu_hold, done, words_loaded, im_addr); mismatched++;
    end
    send_frame(0);
    wait_end("bad_chk");
    check_two_writes("bad_chk");
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 16'd2);
  endtask

  task automatic test_too_long();
    wr_n = 0;
    frame[0] = 8'h01; frame[1] = 8'h01; frame_len = 2;
    pulse_start();
    send_frame(0);
    @(negedge clk);
    check_status("too_long", 1'b0, 1'b1, 1'b1, 16'd0);
    repeat (4) @(negedge clk);
    compared++;
    if (wr_n !== 0) begin
      $display("FAIL too_long writes: got %0d required 0", wr_n); mismatched++;
    end
  endtask

  task automatic test_zero_len();
    wr_n = 0;
    frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00; frame_len = 3;
    pulse_start();
    send_frame(0);
    wait_end("zero_len");
    check_status("zero_len", 1'b1, 1'b0, 1'b0, 16'd0);
    compared++;
    if (wr_n !== 0) begin
      $display("FAIL zero_len writes: got %0d required 0", wr_n); mismatched++;
    end
  endtask

  task automatic test_gapped();
    wr_n = 0;
    load_two_word(8'h93);
    pulse_start();
    for (int i = 0; i < frame_len; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      send_byte(frame[i]);
      if (i == 4) pulse_start();  // lands in DATA and must be ignored
    end
    wait_end("gapped");
    check_two_writes("gapped");
    check_status("gapped", 1'b1, 1'b0, 1'b0, 16'd2);
  endtask

  task automatic test_reset_mid_data();
    load_two_word(8'h93);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(frame[i]);  // length + 6 payload bytes
    @(negedge clk);
    compared++;
    if (words_loaded !== 16'd1 || im_addr !== 32'd4) begin
      $display("FAIL mid_data progress: got words=%0d addr=%h required 1 00000004",
               words_loaded, im_addr); mismatched++;
    end
    wr_n = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || im_addr !== 32'd0 || words_loaded !== 16'd0
        || done !== 1'b0 || error !== 1'b0) begin
      $display("FAIL mid_data reset: got rdy=%b hold=%b addr=%h words=%0d done=%b err=%b required 0 1 0 0 0 0",
               in_ready, cpu_hold, im_addr, words_loaded, done, error); mismatched++;
    end
    in_data = 8'h18; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (wr_n !== 0 || in_ready !== 1'b0) begin
      $display("FAIL mid_data after reset: got writes=%0d rdy=%b required 0 0", wr_n, in_ready);
      mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_back_to_back();
    test_too_long();
    test_zero_len();
    test_gapped();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
